alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
- Sequential execute stage that sits directly upstream of the 8-bit combinational ALU and consumes its outputs.
- Accepts one instruction per handshake, reads two operands from a 4x8 register file, and drives the ALU operand buses and the five select lines.
- Captures the ALU result and carry, then writes the result back to the register file and the carry flag.
- Provides the register/flag state the CPU datapath builds on.

Parameters:
- WIDTH, 8, datapath width; must match the ALU.
- NREG, 4, register-file depth; register index width is log2(NREG) = 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  block can accept; high only in IDLE
- instr_op  in  4  opcode
- instr_rd  in  2  destination register
- instr_ra  in  2  operand A register
- instr_rb  in  2  operand B register
- instr_imm  in  WIDTH  immediate for LDI
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_s  out  5  ALU selects {s4,s3,s2,s1,s0}
- alu_y  in  WIDTH  ALU result
- alu_c  in  1  ALU carry
- done  out  1  one-cycle pulse: instruction retired
- err  out  1  one-cycle pulse with done: illegal opcode
- result  out  WIDTH  value written back; valid with done
- carry_flag  out  1  architectural carry flag
- dbg_sel  in  2  debug register select
- dbg_data  out  WIDTH  combinational read of regfile[dbg_sel]

Behaviour:
- Reset (synchronous, active-high):
  - All regs = 0; carry_flag = 0; state = IDLE.
  - done = err = 0; result = 0; alu_a = alu_b = 0; alu_s = 5'b00000.
- FSM states are IDLE, EXEC and WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid, latch op, rd, imm, regfile[ra] and regfile[rb]; go to EXEC.
- EXEC (one cycle):
  - alu_a and alu_b are registered outputs holding the latched operands.
  - alu_s = decode(op).
  - At the end of the cycle, capture alu_y and alu_c into internal registers, then go to WB.
- WB (one cycle):
  - Legal ALU op: regfile[rd] <= captured y; carry_flag <= captured c.
  - done = 1; result = captured y; go to IDLE.
- Latency and throughput:
  - Accept at edge T; EXEC during T+1; done high during T+2; ready again at T+3.
  - Throughput is one instruction per 3 cycles.
- Opcode decode (alu_s):
  - 0 -> 00000; 1 -> 00001; 2 -> 00010; 3 -> 00011.
  - 4 -> 01100; 5 -> 10100; 6 -> 10000.
  - 7 -> 00100; 8 -> 01000.
- LDI, opcode 4'hF:
  - alu_s = 00000 in EXEC.
  - WB writes instr_imm to rd; result = imm; carry_flag unchanged.
- Illegal opcodes 9 to E:
  - alu_s = 00000 in EXEC.
  - WB asserts done and err; result = 0; no register write; carry unchanged.
- Outside EXEC:
  - alu_s = 00000.
  - alu_a and alu_b hold their last values.
- Hazards and boundaries:
  - instr_valid while instr_ready = 0 is ignored; the source must hold it.
  - No hazard logic is needed. The WB write lands before the next accept, so a back-to-back reader of rd sees the new value.
  - rd == ra == rb is legal; operands are read before the write.
- dbg_data reflects a write from the cycle after the WB edge.
- rst asserted in EXEC or WB:
  - Aborts the instruction: no write, no done pulse.
  - All state is cleared as at reset.

Decomposition:
- Shared package alu_pkg:
  - WIDTH constant.
  - Opcode constants OP_0..OP_8 and OP_LDI.
  - 5-bit select constants SEL_0..SEL_8.
  - State enum {IDLE, EXEC, WB}.
  - decode function op -> select.
- Sub-module regfile_4x8:
  - Two combinational read ports, one debug read port.
  - One synchronous write port with enable; synchronous reset to zero.

Test Plan:
- Reset then idle:
  - Hold rst 2 cycles -> instr_ready = 1; done = 0; carry_flag = 0; alu_s = 00000.
  - dbg_data = 00 for all dbg_sel.
- LDI then ALU op:
  - LDI r1 = F8, then LDI r2 = 1F -> each done pulses 2 cycles after accept; dbg r1 = F8, r2 = 1F.
  - Then op1 rd = r3, ra = r1, rb = r2, with the ALU stub returning y = 17, c = 1:
    - During EXEC: alu_a = F8, alu_b = 1F, alu_s = 00001.
    - Next cycle: done = 1, result = 17; then r3 = 17 and carry_flag = 1.
- Select sweep:
  - Opcodes 0 to 8 back-to-back, instr_valid held high -> alu_s in each EXEC matches the decode table.
  - instr_ready is low for exactly 2 cycles between accepts.
- Illegal opcode:
  - op = A, rd = r0, r0 preloaded = 55 -> done = 1, err = 1, result = 00.
  - r0 stays 55; carry_flag unchanged.
- Read-after-write:
  - op2 writes r0 (stub y = 3C), immediately followed by op0 with ra = r0 -> second EXEC shows alu_a = 3C.
- Mid-op reset:
  - Assert rst during EXEC of a write to r2 (r2 = 1F) -> no done pulse; after reset r2 = 00 and state = IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage.
//   WIDTH / NREG  : datapath width and register-file depth
//   OP_*          : opcode encodings (OP_0..OP_8 drive the ALU, OP_LDI loads an immediate)
//   SEL_*         : 5-bit ALU select patterns {s4,s3,s2,s1,s0}
//   state_e       : execute-stage FSM states
//   decode()      : opcode -> ALU select, zero for LDI and illegal opcodes
package alu_pkg;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned NREG      = 4;
  localparam int unsigned REG_IDX_W = $clog2(NREG);

  localparam logic [3:0] OP_0   = 4'h0;
  localparam logic [3:0] OP_1   = 4'h1;
  localparam logic [3:0] OP_2   = 4'h2;
  localparam logic [3:0] OP_3   = 4'h3;
  localparam logic [3:0] OP_4   = 4'h4;
  localparam logic [3:0] OP_5   = 4'h5;
  localparam logic [3:0] OP_6   = 4'h6;
  localparam logic [3:0] OP_7   = 4'h7;
  localparam logic [3:0] OP_8   = 4'h8;
  localparam logic [3:0] OP_LDI = 4'hF;

  localparam logic [4:0] SEL_0 = 5'b00000;
  localparam logic [4:0] SEL_1 = 5'b00001;
  localparam logic [4:0] SEL_2 = 5'b00010;
  localparam logic [4:0] SEL_3 = 5'b00011;
  localparam logic [4:0] SEL_4 = 5'b01100;
  localparam logic [4:0] SEL_5 = 5'b10100;
  localparam logic [4:0] SEL_6 = 5'b10000;
  localparam logic [4:0] SEL_7 = 5'b00100;
  localparam logic [4:0] SEL_8 = 5'b01000;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  function automatic logic [4:0] decode(input logic [3:0] op);
    case (op)
      OP_0:    return SEL_0;
      OP_1:    return SEL_1;
      OP_2:    return SEL_2;
      OP_3:    return SEL_3;
      OP_4:    return SEL_4;
      OP_5:    return SEL_5;
      OP_6:    return SEL_6;
      OP_7:    return SEL_7;
      OP_8:    return SEL_8;
      default: return SEL_0;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_8;
  endfunction

endpackage

// File: rtl/regfile_4x8.sv
// Small register file.
//   clk, rst          : clock, synchronous active-high reset (clears every entry)
//   we, waddr, wdata  : synchronous write port
//   raddr_a / rdata_a : combinational read port A
//   raddr_b / rdata_b : combinational read port B
//   dbg_sel / dbg_data: combinational debug read port
module regfile_4x8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREG  = 4,
  parameter int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [IDX_W-1:0] raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [IDX_W-1:0] dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem_q[raddr_a];
  assign rdata_b  = mem_q[raddr_b];
  assign dbg_data = mem_q[dbg_sel];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute stage wrapped around an external combinational ALU.
// Accepts one instruction per handshake (IDLE), drives operands and selects to the ALU (EXEC),
// then writes the captured result back (WB). One instruction every three cycles.
//   clk, rst                    : clock, synchronous active-high reset
//   instr_valid / instr_ready   : instruction handshake; ready only in IDLE
//   instr_op/rd/ra/rb/imm       : opcode, destination, operand registers, LDI immediate
//   alu_a, alu_b, alu_s         : registered operands and select lines to the ALU
//   alu_y, alu_c                : ALU result and carry
//   done, err, result           : retire pulse, illegal-opcode flag, written-back value
//   carry_flag                  : architectural carry flag
//   dbg_sel / dbg_data          : combinational register-file peek
module alu_exec_ctrl
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [3:0]           instr_op,
  input  logic [REG_IDX_W-1:0] instr_rd,
  input  logic [REG_IDX_W-1:0] instr_ra,
  input  logic [REG_IDX_W-1:0] instr_rb,
  input  logic [WIDTH-1:0]     instr_imm,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [4:0]           alu_s,
  input  logic [WIDTH-1:0]     alu_y,
  input  logic                 alu_c,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic                 carry_flag,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic [WIDTH-1:0]     dbg_data
);

  state_e               state_q, state_d;
  logic [3:0]           op_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic [WIDTH-1:0]     imm_q, a_q, b_q, y_q;
  logic                 c_q, carry_q;
  logic [WIDTH-1:0]     rdata_a, rdata_b, wdata;
  logic                 accept, is_ldi, is_alu, wb_we;

  assign accept = (state_q == IDLE) && instr_valid;
  assign is_ldi = (op_q == OP_LDI);
  assign is_alu = is_alu_op(op_q);
  assign wb_we  = (state_q == WB) && (is_alu || is_ldi);
  assign wdata  = is_ldi ? imm_q : y_q;

  regfile_4x8 #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we),
    .waddr    (rd_q),
    .wdata    (wdata),
    .raddr_a  (instr_ra),
    .rdata_a  (rdata_a),
    .raddr_b  (instr_rb),
    .rdata_b  (rdata_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == IDLE);
    alu_s       = SEL_0;
    done        = 1'b0;
    err         = 1'b0;
    result      = '0;
    if (state_q == EXEC) begin
      alu_s = decode(op_q);
    end
    if (state_q == WB) begin
      done   = 1'b1;
      err    = !(is_alu || is_ldi);
      result = wb_we ? wdata : '0;
    end
  end

  // Operands are read at accept time, so rd == ra/rb sees the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        imm_q <= instr_imm;
        a_q   <= rdata_a;
        b_q   <= rdata_b;
      end
      if (state_q == EXEC) begin
        y_q <= alu_y;
        c_q <= alu_c;
      end
      if ((state_q == WB) && is_alu) begin
        carry_q <= c_q;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign carry_flag = carry_q;

endmodule
